// File: rtl/display_pkg.sv
// Shared defaults and helpers for the multiplexed display scanner.
package display_pkg;

    localparam int unsigned DEF_N_DIGITS = 4;
    localparam int unsigned DEF_PRESCALE = 1024;
    localparam int unsigned DEF_BLANK    = 16;
    localparam int unsigned MAX_DIGITS   = 8;

    // One-hot common-electrode select for slot i; callers slice to their digit count.
    function automatic logic [MAX_DIGITS-1:0] onehot_sel(input logic [2:0] i);
        return {{(MAX_DIGITS-1){1'b0}}, 1'b1} << i;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot timing: cycle counter within a slot and the slot index, plus blank/frame flags.
module scan_timer
    import display_pkg::*;
#(
    parameter int unsigned N_DIGITS = DEF_N_DIGITS,
    parameter int unsigned PRESCALE = DEF_PRESCALE,
    parameter int unsigned BLANK    = DEF_BLANK
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [$clog2(N_DIGITS)-1:0] slot,
    output logic                        blank_c,
    output logic                        frame_end_c
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam int unsigned IDX_W = $clog2(N_DIGITS);

    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             slot_last;

    assign cnt_last    = (cnt == CNT_W'(PRESCALE - 1));
    assign slot_last   = (slot == IDX_W'(N_DIGITS - 1));
    assign blank_c     = (cnt < CNT_W'(BLANK));
    assign frame_end_c = cnt_last && slot_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            slot <= '0;
        end else if (cnt_last) begin
            cnt  <= '0;
            slot <= slot_last ? '0 : slot + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan.sv
// Multiplexed hex display scanner with frame-synchronous double buffering and leading-zero blanking.
module display_scan
    import display_pkg::*;
#(
    parameter int unsigned N_DIGITS = DEF_N_DIGITS,
    parameter int unsigned PRESCALE = DEF_PRESCALE,
    parameter int unsigned BLANK    = DEF_BLANK
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dots,
    input  logic                  lz_blank,
    output logic [3:0]            tetrade,
    output logic                  dot,
    output logic                  OE,
    output logic [N_DIGITS-1:0]   digit_en,
    output logic                  frame,
    output logic                  pending
);

    localparam int unsigned IDX_W = $clog2(N_DIGITS);

    logic [IDX_W-1:0]      slot;
    logic                  blank_c;
    logic                  frame_end_c;

    logic [4*N_DIGITS-1:0] pend_val;
    logic [N_DIGITS-1:0]   pend_dots;
    logic [4*N_DIGITS-1:0] disp_val;
    logic [N_DIGITS-1:0]   disp_dots;

    logic [3:0]            nib_c;
    logic                  lz_c;
    logic                  lit_c;
    logic [MAX_DIGITS-1:0] sel_c;

    scan_timer #(
        .N_DIGITS (N_DIGITS),
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .slot        (slot),
        .blank_c     (blank_c),
        .frame_end_c (frame_end_c)
    );

    // A digit is suppressed when it and every more-significant digit are zero with no dot.
    assign nib_c = disp_val[{slot, 2'b00} +: 4];
    assign lz_c  = lz_blank && (slot != '0)
                   && ((disp_val >> {slot, 2'b00}) == '0)
                   && !disp_dots[slot];
    assign lit_c = !blank_c && !lz_c;
    assign sel_c = onehot_sel(3'(slot));

    // Pending buffer; display swaps only at the frame boundary so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val  <= '0;
            pend_dots <= '0;
            disp_val  <= '0;
            disp_dots <= '0;
            pending   <= 1'b0;
        end else begin
            if (load) begin
                pend_val  <= value;
                pend_dots <= dots;
            end
            if (frame_end_c) begin
                if (load) begin
                    disp_val  <= value;
                    disp_dots <= dots;
                end else if (pending) begin
                    disp_val  <= pend_val;
                    disp_dots <= pend_dots;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tetrade  <= '0;
            dot      <= 1'b0;
            OE       <= 1'b0;
            digit_en <= '0;
            frame    <= 1'b0;
        end else begin
            tetrade  <= nib_c;
            dot      <= disp_dots[slot];
            OE       <= lit_c;
            digit_en <= lit_c ? sel_c[N_DIGITS-1:0] : '0;
            frame    <= frame_end_c;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Randomised self-checking bench for display_scan (N_DIGITS=4, PRESCALE=8, BLANK=2).
module tb_display_scan;

    localparam int unsigned ND = 4;
    localparam int unsigned PS = 8;
    localparam int unsigned BL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dots = '0;
    logic          lz_blank = 1'b0;
    logic [3:0]    tetrade;
    logic          dot;
    logic          OE;
    logic [3:0]    digit_en;
    logic          frame;
    logic          pending;

    int total = 0;
    int bad = 0;

    // Reference model: elapsed cycles since reset plus shown/queued contents.
    int          k;
    logic [15:0] mval, pval;
    logic [3:0]  mdots, pdots;
    bit          mpend;
    logic        exp_oe, exp_dot, exp_frame, exp_pend;
    logic [3:0]  exp_en, exp_tet;

    display_scan #(.N_DIGITS(ND), .PRESCALE(PS), .BLANK(BL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .dots     (dots),
        .lz_blank (lz_blank),
        .tetrade  (tetrade),
        .dot      (dot),
        .OE       (OE),
        .digit_en (digit_en),
        .frame    (frame),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        k = 0; mval = '0; pval = '0; mdots = '0; pdots = '0; mpend = 0;
    endtask

    // Predict outputs for the coming edge from the current model state and inputs, then clock.
    task automatic step();
        int  s, c;
        bit  sup, bnd;
        s   = (k / PS) % ND;
        c   = k % PS;
        sup = lz_blank && (s > 0) && ((mval >> (4 * s)) == 16'h0) && !mdots[s];
        bnd = (c == PS - 1) && (s == ND - 1);
        exp_oe    = (c >= BL) && !sup;
        exp_en    = exp_oe ? 4'(1 << s) : 4'h0;
        exp_tet   = 4'(mval >> (4 * s));
        exp_dot   = mdots[s];
        exp_frame = bnd;
        if (load) begin
            if (bnd) begin
                mval = value; mdots = dots; mpend = 0;
            end else begin
                pval = value; pdots = dots; mpend = 1;
            end
        end else if (bnd && mpend) begin
            mval = pval; mdots = pdots; mpend = 0;
        end
        exp_pend = mpend;
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic test_reset();
        load = 1'b1; value = 16'hFFFF; dots = 4'hF;
        #23;
        total++;
        if ({OE, digit_en, tetrade, dot, frame, pending} !== 12'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=%b", {OE, digit_en, tetrade, dot, frame, pending}, 12'h0);
        end
        load = 1'b0; value = '0; dots = '0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_idle();
        int frames = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (frame) frames++;
            total++;
            if ({OE, digit_en, tetrade, dot, frame, pending} !== {exp_oe, exp_en, exp_tet, exp_dot, exp_frame, exp_pend}) begin
                bad++;
                $display("FAIL idle k=%0d got=%b exp=%b", k, {OE, digit_en, tetrade, dot, frame, pending},
                         {exp_oe, exp_en, exp_tet, exp_dot, exp_frame, exp_pend});
            end
        end
        total++;
        if (frames != 2) begin
            bad++;
            $display("FAIL idle_frame_count got=%0d exp=2", frames);
        end
    endtask

    task automatic test_load_mid();
        for (int i = 0; i < 10; i++) step();
        load = 1'b1; value = 16'h1234; dots = 4'b0100;
        step();
        load = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            total++;
            if ({OE, digit_en, tetrade, dot, frame, pending} !== {exp_oe, exp_en, exp_tet, exp_dot, exp_frame, exp_pend}) begin
                bad++;
                $display("FAIL load_mid k=%0d got=%b exp=%b", k, {OE, digit_en, tetrade, dot, frame, pending},
                         {exp_oe, exp_en, exp_tet, exp_dot, exp_frame, exp_pend});
            end
        end
    endtask

    task automatic test_last_wins();
        int saw_a = 0;
        while ((k % (PS * ND)) != 5) step();
        load = 1'b1; value = 16'hAAAA; dots = 4'h0;
        step();
        load = 1'b0;
        step(); step();
        load = 1'b1; value = 16'h5555;
        step();
        load = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (tetrade === 4'hA) saw_a++;
            total++;
            if ({OE, digit_en, tetrade, dot, frame, pending} !== {exp_oe, exp_en, exp_tet, exp_dot, exp_frame, exp_pend}) begin
                bad++;
                $display("FAIL last_wins k=%0d got=%b exp=%b", k, {OE, digit_en, tetrade, dot, frame, pending},
                         {exp_oe, exp_en, exp_tet, exp_dot, exp_frame, exp_pend});
            end
        end
        total++;
        if (saw_a != 0) begin
            bad++;
            $display("FAIL last_wins_no_a got=%0d exp=0", saw_a);
        end
    endtask

    task automatic test_boundary_load();
        while ((k % (PS * ND)) != PS * ND - 1) step();
        load = 1'b1; value = 16'h00F0; dots = 4'h0;
        step();
        load = 1'b0;
        total++;
        if (pending !== 1'b0) begin
            bad++;
            $display("FAIL boundary_pending got=%b exp=0", pending);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            total++;
            if ({OE, digit_en, tetrade, dot, frame, pending} !== {exp_oe, exp_en, exp_tet, exp_dot, exp_frame, exp_pend}) begin
                bad++;
                $display("FAIL boundary k=%0d got=%b exp=%b", k, {OE, digit_en, tetrade, dot, frame, pending},
                         {exp_oe, exp_en, exp_tet, exp_dot, exp_frame, exp_pend});
            end
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals [3] = '{16'h0007, 16'h0000, 16'h0000};
        logic [3:0]  dts  [3] = '{4'b0000, 4'b0000, 4'b1000};
        lz_blank = 1'b1;
        for (int p = 0; p < 3; p++) begin
            load = 1'b1; value = vals[p]; dots = dts[p];
            step();
            load = 1'b0;
            for (int i = 0; i < 64; i++) begin
                step();
                total++;
                if ({OE, digit_en, tetrade, dot, frame, pending} !== {exp_oe, exp_en, exp_tet, exp_dot, exp_frame, exp_pend}) begin
                    bad++;
                    $display("FAIL lz p=%0d k=%0d got=%b exp=%b", p, k, {OE, digit_en, tetrade, dot, frame, pending},
                             {exp_oe, exp_en, exp_tet, exp_dot, exp_frame, exp_pend});
                end
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 11) == 0);
            value = 16'($urandom);
            if ($urandom_range(0, 1) == 0) value = value & 16'h00FF;
            dots = 4'($urandom);
            if ($urandom_range(0, 1) == 0) dots = 4'h0;
            if ($urandom_range(0, 7) == 0) lz_blank = ~lz_blank;
            step();
            total++;
            if ({OE, digit_en, tetrade, dot, frame, pending} !== {exp_oe, exp_en, exp_tet, exp_dot, exp_frame, exp_pend}) begin
                bad++;
                $display("FAIL random k=%0d got=%b exp=%b", k, {OE, digit_en, tetrade, dot, frame, pending},
                         {exp_oe, exp_en, exp_tet, exp_dot, exp_frame, exp_pend});
            end
        end
        load = 1'b0; lz_blank = 1'b0;
    endtask

    task automatic test_async_reset();
        load = 1'b1; value = 16'h1234; dots = 4'b0100;
        step();
        load = 1'b0;
        for (int i = 0; i < 40; i++) step();
        load = 1'b1; value = 16'h9876;
        step();
        load = 1'b0;
        step(); step(); step();
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({OE, digit_en, tetrade, dot, frame, pending} !== 12'h0) begin
            bad++;
            $display("FAIL async_reset got=%b exp=%b", {OE, digit_en, tetrade, dot, frame, pending}, 12'h0);
        end
        #2 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            step();
            total++;
            if ({OE, digit_en, tetrade, dot, frame, pending} !== {exp_oe, exp_en, exp_tet, exp_dot, exp_frame, exp_pend}) begin
                bad++;
                $display("FAIL post_reset k=%0d got=%b exp=%b", k, {OE, digit_en, tetrade, dot, frame, pending},
                         {exp_oe, exp_en, exp_tet, exp_dot, exp_frame, exp_pend});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_load_mid();
        test_last_wins();
        test_boundary_load();
        test_lz();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
